// File: rtl/prach_ditfft3_seq.sv
`default_nettype none
// ============================================================================
// Module      : prach_ditfft3_seq
// Description : Frame sequencer in front of the PRACH radix-3 DIT butterfly.
//               Arms on start, forwards LEN upstream samples with index,
//               triplet position and frame sync, then flushes and reports
//               frame_done. Overrun and inter-sample timeout are flagged.
//               Assumes LEN is a multiple of 3 (>= 3), FLUSH >= 1 and
//               TIMEOUT >= 1.
// Revision    : 1.0 - initial release
// ============================================================================
module prach_ditfft3_seq #(
  parameter int unsigned LEN     = 243,
  parameter int unsigned FLUSH   = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [17:0]            din_dr,
  input  logic [17:0]            din_di,
  input  logic                   din_dv,
  output logic [17:0]            dout_dr,
  output logic [17:0]            dout_di,
  output logic                   dout_dv,
  output logic                   sync_out,
  output logic [$clog2(LEN)-1:0] sample_idx,
  output logic [1:0]             trip_idx,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_overrun,
  output logic                   err_timeout
);

  localparam int unsigned CNT_W = $clog2(LEN);
  localparam int unsigned GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned FL_W  = (FLUSH > 1) ? $clog2(FLUSH) : 1;

  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(LEN - 1);
  localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(TIMEOUT - 1);
  localparam logic [FL_W-1:0]  c_fl_last  = FL_W'(FLUSH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;    // index of the next sample to accept
  logic [1:0]       r_trip,  w_trip_nxt;   // triplet position of the next sample
  logic [GAP_W-1:0] r_gap,   w_gap_nxt;    // consecutive idle cycles in RUN
  logic [FL_W-1:0]  r_fl,    w_fl_nxt;     // cycles spent in FLUSH
  logic             w_fwd, w_sync, w_done, w_ovr, w_tmo;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_trip  <= '0;
      r_gap   <= '0;
      r_fl    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trip  <= w_trip_nxt;
      r_gap   <= w_gap_nxt;
      r_fl    <= w_fl_nxt;
    end
  end

  // Next-state, counter updates and pulse requests for the output stage
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_trip_nxt  = r_trip;
    w_gap_nxt   = r_gap;
    w_fl_nxt    = r_fl;
    w_fwd       = 1'b0;
    w_sync      = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    // Any start outside IDLE, including the final FLUSH cycle, is an overrun
    w_ovr       = start && (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ARMED;
          w_cnt_nxt   = '0;
          w_trip_nxt  = '0;
          w_gap_nxt   = '0;
          w_fl_nxt    = '0;
        end
      end
      S_ARMED, S_RUN: begin
        if (din_dv) begin
          w_fwd      = 1'b1;
          w_sync     = (r_state == S_ARMED);
          w_gap_nxt  = '0;
          w_trip_nxt = (r_trip == 2'd2) ? 2'd0 : r_trip + 2'd1;
          if (r_cnt == c_last_idx) begin
            w_state_nxt = S_FLUSH;
            w_fl_nxt    = '0;
          end else begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end else if (r_state == S_RUN) begin
          // ARMED may wait forever; only RUN is guarded by the gap timer
          if (r_gap == c_gap_last) begin
            w_tmo       = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_gap_nxt = r_gap + GAP_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (r_fl == c_fl_last) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_fl_nxt = r_fl + FL_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs; sample payload only updates on a forwarded sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_dr     <= '0;
      dout_di     <= '0;
      dout_dv     <= 1'b0;
      sync_out    <= 1'b0;
      sample_idx  <= '0;
      trip_idx    <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      dout_dv     <= w_fwd;
      sync_out    <= w_sync;
      busy        <= (w_state_nxt != S_IDLE);
      frame_done  <= w_done;
      err_overrun <= w_ovr;
      err_timeout <= w_tmo;
      if (w_fwd) begin
        dout_dr    <= din_dr;
        dout_di    <= din_di;
        sample_idx <= r_cnt;
        trip_idx   <= r_trip;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prach_ditfft3_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_prach_ditfft3_seq
// Description : Self-checking bench for prach_ditfft3_seq (LEN=9, FLUSH=2,
//               TIMEOUT=4) with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prach_ditfft3_seq;

  localparam int LEN     = 9;
  localparam int FLUSH   = 2;
  localparam int TIMEOUT = 4;
  localparam int IW      = $clog2(LEN);

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_FLUSH = 3;

  logic          clk = 1'b0;
  logic          rst_n, start, din_dv;
  logic [17:0]   din_dr, din_di;
  logic [17:0]   dout_dr, dout_di;
  logic          dout_dv, sync_out, busy, frame_done, err_overrun, err_timeout;
  logic [IW-1:0] sample_idx;
  logic [1:0]    trip_idx;

  prach_ditfft3_seq #(.LEN(LEN), .FLUSH(FLUSH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .din_dr     (din_dr),
    .din_di     (din_di),
    .din_dv     (din_dv),
    .dout_dr    (dout_dr),
    .dout_di    (dout_di),
    .dout_dv    (dout_dv),
    .sync_out   (sync_out),
    .sample_idx (sample_idx),
    .trip_idx   (trip_idx),
    .busy       (busy),
    .frame_done (frame_done),
    .err_overrun(err_overrun),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame phase, samples accepted, idle run, flush cycles
  int          m_mode, m_acc, m_idle, m_fl;
  logic [17:0] e_dr, e_di;
  logic        e_dv, e_sync, e_busy, e_done, e_ovr, e_tmo;
  int          e_idx, e_trip;

  // Observations gathered per scenario
  int          cyc = 0;
  int          done_cnt, tmo_cnt, ovr_cnt, dv_cnt, last_dv_cyc, done_cyc;
  logic [17:0] obs_dr[$];
  int          obs_idx[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] rnd18();
    return 18'($urandom());
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_acc = 0; m_idle = 0; m_fl = 0;
    e_dr = '0; e_di = '0; e_dv = 1'b0; e_sync = 1'b0; e_idx = 0; e_trip = 0;
    e_busy = 1'b0; e_done = 1'b0; e_ovr = 1'b0; e_tmo = 1'b0;
  endtask

  // Expected outputs after one rising edge with the given inputs
  task automatic model_step(input logic s, input logic v, input logic [17:0] r,
                            input logic [17:0] i, input logic rn);
    if (!rn) begin
      model_reset();
    end else begin
      e_dv = 1'b0; e_sync = 1'b0; e_done = 1'b0; e_tmo = 1'b0;
      e_ovr = s && (m_mode != M_IDLE);
      case (m_mode)
        M_IDLE: if (s) begin m_mode = M_ARMED; m_acc = 0; m_idle = 0; end
        M_ARMED, M_RUN: begin
          if (v) begin
            e_dv = 1'b1; e_sync = (m_acc == 0);
            e_dr = r; e_di = i; e_idx = m_acc; e_trip = m_acc % 3;
            m_acc++; m_idle = 0;
            if (m_acc == LEN) begin m_mode = M_FLUSH; m_fl = 0; end
            else m_mode = M_RUN;
          end else if (m_mode == M_RUN) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin e_tmo = 1'b1; m_mode = M_IDLE; end
          end
        end
        default: begin
          m_fl++;
          if (m_fl == FLUSH) begin e_done = 1'b1; m_mode = M_IDLE; end
        end
      endcase
      e_busy = (m_mode != M_IDLE);
    end
  endtask

  task automatic cyc_step(input logic s, input logic v, input logic [17:0] r,
                          input logic [17:0] i, input logic rn);
    start = s; din_dv = v; din_dr = r; din_di = i; rst_n = rn;
    @(posedge clk);
    model_step(s, v, r, i, rn);
    #1;
    cyc++;
    check("dout_dv",     dout_dv,     e_dv);
    check("sync_out",    sync_out,    e_sync);
    check("dout_dr",     dout_dr,     e_dr);
    check("dout_di",     dout_di,     e_di);
    check("sample_idx",  sample_idx,  e_idx);
    check("trip_idx",    trip_idx,    e_trip);
    check("busy",        busy,        e_busy);
    check("frame_done",  frame_done,  e_done);
    check("err_overrun", err_overrun, e_ovr);
    check("err_timeout", err_timeout, e_tmo);
    if (frame_done)  begin done_cnt++; done_cyc = cyc; end
    if (err_timeout) tmo_cnt++;
    if (err_overrun) ovr_cnt++;
    if (dout_dv) begin
      dv_cnt++; last_dv_cyc = cyc;
      obs_dr.push_back(dout_dr);
      obs_idx.push_back(int'(sample_idx));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cyc_step(1'b0, 1'b0, rnd18(), rnd18(), 1'b1);
  endtask

  task automatic send(input logic s, input logic [17:0] r);
    cyc_step(s, 1'b1, r, rnd18(), 1'b1);
  endtask

  task automatic clear_obs();
    done_cnt = 0; tmo_cnt = 0; ovr_cnt = 0; dv_cnt = 0; last_dv_cyc = 0; done_cyc = 0;
    obs_dr.delete(); obs_idx.delete();
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      cyc_step(1'b0, 1'b0, rnd18(), rnd18(), 1'b1);
      if (frame_done) break;
    end
  endtask

  task automatic check_index_order(input string tag);
    check({tag, "_count"}, obs_idx.size(), LEN);
    for (int k = 0; k < obs_idx.size(); k++) check({tag, "_idx"}, obs_idx[k], k);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; din_dv = 1'b0; din_dr = '0; din_di = '0;
    model_reset();
    clear_obs();

    // Reset holds everything at zero even with start and data present
    repeat (3) cyc_step(1'b1, 1'b1, rnd18(), rnd18(), 1'b0);

    // Data in IDLE without start is ignored
    clear_obs();
    repeat (4) cyc_step(1'b0, 1'b1, rnd18(), rnd18(), 1'b1);
    check("idle_dv_cnt", dv_cnt, 0);

    // Back-to-back frame with data 1..9
    clear_obs();
    cyc_step(1'b1, 1'b0, rnd18(), rnd18(), 1'b1);
    for (int k = 1; k <= LEN; k++) send(1'b0, 18'(k));
    wait_done(8);
    check("b2b_count", obs_dr.size(), LEN);
    for (int k = 0; k < obs_dr.size(); k++) check("b2b_data", obs_dr[k], k + 1);
    check("b2b_done_cnt", done_cnt, 1);
    check("b2b_done_lag", done_cyc - last_dv_cyc, 2);
    check("b2b_busy_after", busy, 0);

    // Gapped frame, with a long wait in ARMED first
    clear_obs();
    cyc_step(1'b1, 1'b0, rnd18(), rnd18(), 1'b1);
    idle_cycles(6);
    for (int k = 0; k < LEN; k++) begin
      send(1'b0, rnd18());
      if (k < LEN - 1) idle_cycles($urandom_range(1, 3));
    end
    wait_done(8);
    check_index_order("gap");
    check("gap_done_cnt", done_cnt, 1);
    check("gap_tmo_cnt", tmo_cnt, 0);

    // Timeout after 5 samples, later data not forwarded
    clear_obs();
    cyc_step(1'b1, 1'b0, rnd18(), rnd18(), 1'b1);
    repeat (5) send(1'b0, rnd18());
    idle_cycles(TIMEOUT);
    check("tmo_cnt", tmo_cnt, 1);
    check("tmo_busy", busy, 0);
    repeat (4) send(1'b0, rnd18());
    idle_cycles(4);
    check("tmo_done_cnt", done_cnt, 0);
    check("tmo_dv_cnt", dv_cnt, 5);

    // Overrun in RUN and in the final FLUSH cycle; start right at frame_done accepted
    clear_obs();
    cyc_step(1'b1, 1'b0, rnd18(), rnd18(), 1'b1);
    for (int k = 0; k < LEN; k++) send(k == 3, rnd18());
    idle_cycles(1);
    cyc_step(1'b1, 1'b0, rnd18(), rnd18(), 1'b1);
    check("ovr_done_cnt", done_cnt, 1);
    check("ovr_cnt", ovr_cnt, 2);
    check_index_order("ovr");
    cyc_step(1'b1, 1'b0, rnd18(), rnd18(), 1'b1);
    check("ovr_restart_busy", busy, 1);
    for (int k = 0; k < LEN; k++) begin
      send(1'b0, rnd18());
      idle_cycles($urandom_range(0, 2));
    end
    wait_done(8);
    check("ovr_done_cnt2", done_cnt, 2);
    check("ovr_cnt2", ovr_cnt, 2);
    check("ovr_dv_cnt", dv_cnt, 2 * LEN);

    // Reset mid-frame at sample 4
    clear_obs();
    cyc_step(1'b1, 1'b0, rnd18(), rnd18(), 1'b1);
    repeat (4) send(1'b0, rnd18());
    cyc_step(1'b0, 1'b1, rnd18(), rnd18(), 1'b0);
    check("rst_mid_dv", dout_dv, 0);
    clear_obs();
    repeat (3) send(1'b0, rnd18());
    idle_cycles(TIMEOUT + 1);
    check("rst_ignored_dv", dv_cnt, 0);
    check("rst_no_pulses", done_cnt + tmo_cnt + ovr_cnt, 0);
    clear_obs();
    cyc_step(1'b1, 1'b0, rnd18(), rnd18(), 1'b1);
    for (int k = 0; k < LEN; k++) send(1'b0, rnd18());
    wait_done(8);
    check_index_order("rst_next");
    check("rst_next_done", done_cnt, 1);

    // Randomised soak against the model
    begin
      int pdv;
      pdv = 70;
      for (int n = 0; n < 600; n++) begin
        if (n % 50 == 0) pdv = ($urandom_range(0, 2) == 0) ? 30 : (($urandom_range(0, 1) == 0) ? 70 : 95);
        cyc_step($urandom_range(0, 19) == 0, $urandom_range(0, 99) < pdv,
                 rnd18(), rnd18(), $urandom_range(0, 149) != 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
